multi_channel_dma_engine: RTL and testbench

Parametrised DMA issue engine: NUM_CH independent copy channels, each programmed with source, destination and beat count, feeding one shared request stream through a round-robin arbiter with valid/ready back-pressure. Generalises the fixed four-channel start/done DMA status of the main data-processing IP. It adds:
- real length counting and address stepping;
- a per-channel completion pulse and busy-start error reporting;
- optional performance counters.

It sits in the clk_main_200mhz domain between the control registers and the memory-request fabric.

---
 rtl/multi_channel_dma_engine.sv | 148 ++++++++++++++
 tb/tb_multi_channel_dma_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_dma_engine.sv
// multi_channel_dma_engine: NUM_CH copy channels issuing beats round-robin onto one valid/ready request stream.
// Ports: clk_main_200mhz/reset (sync, active-high); ch_src_addr/ch_dst_addr/ch_length/ch_start program channels;
// ch_busy/ch_done/ch_error report per-channel status; req_* is the registered request stream;
// perf_beats/perf_stall are saturating counters, present only when DMA_ENGINE_PERF_EN is defined (else tied 0).
module multi_channel_dma_engine #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 16,
  parameter int BEAT_BYTES = 4,
  parameter int CNT_W = 32,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_main_200mhz,
  input  logic                     reset,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_length,
  input  logic [NUM_CH-1:0]        ch_start,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_error,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [ADDR_W-1:0]        req_src_addr,
  output logic [ADDR_W-1:0]        req_dst_addr,
  output logic [CH_W-1:0]          req_channel,
  output logic                     req_last,
  output logic [CNT_W-1:0]         perf_beats,
  output logic [CNT_W-1:0]         perf_stall
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} st_e;
  st_e               st_q [NUM_CH], st_d [NUM_CH];
  logic [ADDR_W-1:0] src_q [NUM_CH], src_d [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH], dst_d [NUM_CH];
  logic [LEN_W-1:0]  rem_q [NUM_CH], rem_d [NUM_CH];
  logic [NUM_CH-1:0] err_q, err_d, active;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d, grant, idx, req_ch_q, req_ch_d;
  logic [ADDR_W-1:0] req_src_q, req_src_d, req_dst_q, req_dst_d;
  logic              req_valid_q, req_valid_d, req_last_q, req_last_d;
  logic              found, load, accept, gi;
  always_comb begin
    active = '0;
    found = 1'b0;
    grant = '0;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++) active[k] = (st_q[k] == ACTIVE);
    // First ACTIVE channel at or after rr_ptr, wrapping modulo NUM_CH.
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!found && active[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    load = (!req_valid_q || req_ready) && found;
    accept = req_valid_q && req_ready;
    rr_ptr_d = load ? CH_W'((int'(grant) + 1) % NUM_CH) : rr_ptr_q;
    req_valid_d = load || (req_valid_q && !req_ready);
    req_src_d = load ? src_q[grant] : req_src_q;
    req_dst_d = load ? dst_q[grant] : req_dst_q;
    req_ch_d = load ? grant : req_ch_q;
    req_last_d = load ? (rem_q[grant] == LEN_W'(1)) : req_last_q;
    gi = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i] = st_q[i];
      src_d[i] = src_q[i];
      dst_d[i] = dst_q[i];
      rem_d[i] = rem_q[i];
      err_d[i] = err_q[i] | (ch_start[i] && st_q[i] != IDLE);
      gi = load && grant == CH_W'(i);
      case (st_q[i])
        IDLE: if (ch_start[i]) begin
          src_d[i] = ch_src_addr[i*ADDR_W +: ADDR_W];
          dst_d[i] = ch_dst_addr[i*ADDR_W +: ADDR_W];
          rem_d[i] = ch_length[i*LEN_W +: LEN_W];
          err_d[i] = 1'b0;
          st_d[i] = (ch_length[i*LEN_W +: LEN_W] != '0) ? ACTIVE : DONE;
        end
        ACTIVE: if (gi) begin
          src_d[i] = src_q[i] + ADDR_W'(BEAT_BYTES);
          dst_d[i] = dst_q[i] + ADDR_W'(BEAT_BYTES);
          rem_d[i] = rem_q[i] - LEN_W'(1);
          st_d[i] = (rem_q[i] == LEN_W'(1)) ? DRAIN : ACTIVE;
        end
        DRAIN: st_d[i] = (accept && req_last_q && req_ch_q == CH_W'(i)) ? DONE : DRAIN;
        default: st_d[i] = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_main_200mhz) begin
    if (reset) begin
      st_q <= '{default: IDLE};
      src_q <= '{default: '0};
      dst_q <= '{default: '0};
      rem_q <= '{default: '0};
      err_q <= '0;
      rr_ptr_q <= '0;
      req_valid_q <= 1'b0;
      req_src_q <= '0;
      req_dst_q <= '0;
      req_ch_q <= '0;
      req_last_q <= 1'b0;
    end else begin
      st_q <= st_d;
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      err_q <= err_d;
      rr_ptr_q <= rr_ptr_d;
      req_valid_q <= req_valid_d;
      req_src_q <= req_src_d;
      req_dst_q <= req_dst_d;
      req_ch_q <= req_ch_d;
      req_last_q <= req_last_d;
    end
  end
  always_comb begin
    ch_busy = '0;
    ch_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busy[i] = (st_q[i] != IDLE);
      ch_done[i] = (st_q[i] == DONE);
    end
  end
  assign ch_error = err_q;
  assign req_valid = req_valid_q;
  assign req_src_addr = req_src_q;
  assign req_dst_addr = req_dst_q;
  assign req_channel = req_ch_q;
  assign req_last = req_last_q;
`ifdef DMA_ENGINE_PERF_EN
  logic [CNT_W-1:0] beats_q, stall_q;
  always_ff @(posedge clk_main_200mhz) begin
    if (reset) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      if (accept && !(&beats_q)) beats_q <= beats_q + CNT_W'(1);
      if (req_valid_q && !req_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
    end
  end
  assign perf_beats = beats_q;
  assign perf_stall = stall_q;
`else
  assign perf_beats = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_multi_channel_dma_engine.sv
// tb_multi_channel_dma_engine: directed plus random stimulus against a queue-based reference model.
module tb_multi_channel_dma_engine;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ch_src_addr, ch_dst_addr;
  logic [63:0]  ch_length;
  logic [3:0]   ch_start;
  logic [3:0]   ch_busy, ch_done, ch_error;
  logic         req_valid, req_ready, req_last;
  logic [31:0]  req_src_addr, req_dst_addr, perf_beats, perf_stall;
  logic [1:0]   req_channel;
  int checks = 0;
  int fails = 0;

  multi_channel_dma_engine dut (
    .clk_main_200mhz(clk), .reset(reset),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_length(ch_length), .ch_start(ch_start),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_error(ch_error),
    .req_valid(req_valid), .req_ready(req_ready), .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
    .req_channel(req_channel), .req_last(req_last), .perf_beats(perf_beats), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  logic [63:0] q [4][$];
  logic        mv, mlast, mfields;
  logic [31:0] msrc, mdst;
  logic [1:0]  mch, ptr;
  logic [3:0]  mbusy, mdone, merr;
  int unsigned mbeats, mstall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [3:0] st, input logic rd, input logic rs);
    logic [3:0] busy_pre, nd;
    logic [31:0] s, d;
    logic found;
    int g;
    int len;
    if (rs) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      {mv, mlast, msrc, mdst, mch, ptr, mbusy, mdone, merr} = '0;
      mbeats = 0;
      mstall = 0;
      mfields = 1'b1;
      return;
    end
    busy_pre = mbusy;
    nd = '0;
    if (mv && rd) begin
      mbeats++;
      if (mlast) nd[mch] = 1'b1;
    end
    if (mv && !rd) mstall++;
    mbusy &= ~mdone;
    found = 1'b0;
    g = 0;
    if (!mv || rd)
      for (int k = 0; k < 4; k++)
        if (!found && q[(int'(ptr) + k) % 4].size() > 0) begin
          found = 1'b1;
          g = (int'(ptr) + k) % 4;
        end
    if (found) begin
      {msrc, mdst} = q[g].pop_front();
      mch = 2'(g);
      mlast = (q[g].size() == 0);
      mv = 1'b1;
      mfields = 1'b0;
      ptr = 2'((g + 1) % 4);
    end else if (rd) mv = 1'b0;
    for (int i = 0; i < 4; i++)
      if (st[i]) begin
        if (busy_pre[i]) merr[i] = 1'b1;
        else begin
          merr[i] = 1'b0;
          mbusy[i] = 1'b1;
          len = int'(ch_length[i*16 +: 16]);
          s = ch_src_addr[i*32 +: 32];
          d = ch_dst_addr[i*32 +: 32];
          if (len == 0) nd[i] = 1'b1;
          for (int b = 0; b < len; b++) q[i].push_back({s + 32'(4*b), d + 32'(4*b)});
        end
      end
    mdone = nd;
  endtask

  task automatic compare();
    check("req_valid", 64'(req_valid), 64'(mv));
    check("ch_busy", 64'(ch_busy), 64'(mbusy));
    check("ch_done", 64'(ch_done), 64'(mdone));
    check("ch_error", 64'(ch_error), 64'(merr));
    if (mv || mfields) begin
      check("req_src", 64'(req_src_addr), 64'(msrc));
      check("req_dst", 64'(req_dst_addr), 64'(mdst));
      check("req_channel", 64'(req_channel), 64'(mch));
      check("req_last", 64'(req_last), 64'(mlast));
    end
`ifdef DMA_ENGINE_PERF_EN
    check("perf_beats", 64'(perf_beats), 64'(mbeats));
    check("perf_stall", 64'(perf_stall), 64'(mstall));
`else
    check("perf_beats", 64'(perf_beats), 64'(0));
    check("perf_stall", 64'(perf_stall), 64'(0));
`endif
  endtask

  task automatic cycle(input logic [3:0] st, input logic rd, input logic rs);
    ch_start = st;
    req_ready = rd;
    reset = rs;
    model(st, rd, rs);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic prog(input int c, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    ch_src_addr[c*32 +: 32] = s;
    ch_dst_addr[c*32 +: 32] = d;
    ch_length[c*16 +: 16] = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0, 1'b1, 1'b0);
  endtask

  initial begin
    ch_src_addr = '0;
    ch_dst_addr = '0;
    ch_length = '0;
    cycle(4'b1111, 1'b1, 1'b1);
    cycle(4'b0, 1'b1, 1'b1);
    prog(0, 32'h1000, 32'h2000, 16'd3);
    cycle(4'b0001, 1'b1, 1'b0);
    idle(7);
    for (int c = 0; c < 4; c++) prog(c, 32'h100 * c, 32'h8000 + 32'h100 * c, 16'd2);
    cycle(4'b1111, 1'b1, 1'b0);
    idle(14);
    prog(0, 32'h4000, 32'h5000, 16'd6);
    cycle(4'b0001, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) cycle(4'b0, 1'b0, 1'b0);
    idle(10);
    prog(1, 32'h10, 32'h20, 16'd0);
    prog(2, 32'h3000, 32'h6000, 16'd4);
    cycle(4'b0110, 1'b1, 1'b0);
    prog(2, 32'hdead0000, 32'hbeef0000, 16'd9);
    cycle(4'b0100, 1'b1, 1'b0);
    idle(8);
    prog(2, 32'h7000, 32'h7100, 16'd1);
    cycle(4'b0100, 1'b1, 1'b0);
    idle(5);
    prog(3, 32'hFFFFFFFC, 32'hFFFFFFF8, 16'd2);
    cycle(4'b1000, 1'b1, 1'b0);
    idle(6);
    prog(0, 32'h9000, 32'hA000, 16'd8);
    cycle(4'b0001, 1'b1, 1'b0);
    idle(2);
    cycle(4'b0001, 1'b1, 1'b1);
    idle(6);
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] st;
      st = '0;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 7) == 0) begin
          st[c] = 1'b1;
          prog(c, ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4) : $urandom,
               $urandom, 16'($urandom_range(0, 5)));
        end
      cycle(st, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
    end
    idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
